// File: rtl/syscall_unit.sv
// syscall_unit: executes print-int, print-char and exit syscalls for the pipelined MIPS core,
// streaming ASCII bytes to the console port and stalling the front end until the service completes.
module syscall_unit #(
   parameter logic [31:0] CODE_PRINT_INT  = 32'd1,
   parameter logic [31:0] CODE_EXIT       = 32'd10,
   parameter logic [31:0] CODE_PRINT_CHAR = 32'd11
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        syscall_valid,
   input  logic [31:0] v0,
   input  logic [31:0] a0,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        busy,
   output logic        halted
);
   typedef enum logic [2:0] {S_IDLE, S_SIGN, S_CONV, S_EMIT, S_DONE, S_HALT} state_t;

   state_t      r_state, w_state;
   logic [31:0] r_mag, w_mag, w_pow;
   logic [3:0]  r_p, w_p, r_digit, w_digit;
   logic        r_nz, w_nz, r_last, w_last, r_sign, w_sign;
   logic [7:0]  r_out, w_out;

   function automatic logic [31:0] f_pow(input logic [3:0] p);
      case (p)
         4'd9:    return 32'd1000000000;
         4'd8:    return 32'd100000000;
         4'd7:    return 32'd10000000;
         4'd6:    return 32'd1000000;
         4'd5:    return 32'd100000;
         4'd4:    return 32'd10000;
         4'd3:    return 32'd1000;
         4'd2:    return 32'd100;
         4'd1:    return 32'd10;
         default: return 32'd1;
      endcase
   endfunction

   assign w_pow = f_pow(r_p);

   always_comb begin
      w_state = r_state;
      w_mag   = r_mag;
      w_p     = r_p;
      w_digit = r_digit;
      w_nz    = r_nz;
      w_last  = r_last;
      w_sign  = r_sign;
      w_out   = r_out;
      case (r_state)
         S_IDLE: if (syscall_valid) begin
            w_p     = 4'd9;
            w_digit = 4'd0;
            w_nz    = 1'b0;
            w_last  = 1'b0;
            w_sign  = 1'b0;
            if (v0 == CODE_PRINT_CHAR) begin
               w_out   = a0[7:0];
               w_last  = 1'b1;
               w_state = S_EMIT;
            end else if (v0 == CODE_PRINT_INT) begin
               w_mag   = a0[31] ? ~a0 + 32'd1 : a0;
               w_state = a0[31] ? S_SIGN : S_CONV;
            end else begin
               w_state = (v0 == CODE_EXIT) ? S_HALT : S_DONE;
            end
         end
         S_SIGN: begin
            w_out   = 8'h2D;
            w_sign  = 1'b1;
            w_state = S_EMIT;
         end
         S_CONV: begin
            // Restoring division by 10^p: one subtract per cycle, digit counts the subtractions.
            if (r_mag >= w_pow) begin
               w_mag   = r_mag - w_pow;
               w_digit = r_digit + 4'd1;
            end else if (r_digit != 4'd0 || r_nz || r_p == 4'd0) begin
               w_out   = 8'h30 + {4'h0, r_digit};
               w_nz    = 1'b1;
               w_last  = (r_p == 4'd0);
               w_sign  = 1'b0;
               w_state = S_EMIT;
            end else begin
               w_p     = r_p - 4'd1;
               w_digit = 4'd0;
            end
         end
         S_EMIT: if (out_ready) begin
            if (r_last) begin
               w_state = S_DONE;
            end else if (r_sign) begin
               w_sign  = 1'b0;
               w_state = S_CONV;
            end else begin
               w_p     = r_p - 4'd1;
               w_digit = 4'd0;
               w_state = S_CONV;
            end
         end
         S_DONE:  w_state = S_IDLE;
         S_HALT:  w_state = S_HALT;
         default: w_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_mag   <= '0;
         r_p     <= '0;
         r_digit <= '0;
         r_nz    <= 1'b0;
         r_last  <= 1'b0;
         r_sign  <= 1'b0;
         r_out   <= '0;
      end else begin
         r_state <= w_state;
         r_mag   <= w_mag;
         r_p     <= w_p;
         r_digit <= w_digit;
         r_nz    <= w_nz;
         r_last  <= w_last;
         r_sign  <= w_sign;
         r_out   <= w_out;
      end
   end

   // DONE drops busy for exactly one cycle so decode advances past the syscall once.
   assign busy      = (r_state == S_IDLE) ? syscall_valid : (r_state != S_DONE);
   assign halted    = (r_state == S_HALT);
   assign out_valid = (r_state == S_EMIT);
   assign out_data  = r_out;
endmodule

// File: tb/tb_syscall_unit.sv
// tb_syscall_unit: directed syscall sequences checked against a decimal-string/cycle-cost model
// of the console output and busy duration.
module tb_syscall_unit;
   logic        clk = 1'b0, rst_n = 1'b0, syscall_valid = 1'b0, out_ready = 1'b1;
   logic [31:0] v0 = '0, a0 = '0;
   logic        out_valid, busy, halted;
   logic [7:0]  out_data;
   int          checks = 0, errors = 0;
   byte unsigned exp_q[$], got_q[$];
   logic        p_valid = 1'b0, p_ready = 1'b0;
   logic [7:0]  p_data = '0;

   always #5 clk = ~clk;

   syscall_unit dut (
      .clk(clk), .rst_n(rst_n), .syscall_valid(syscall_valid), .v0(v0), .a0(a0),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .busy(busy), .halted(halted)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge rst_n) p_valid = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (p_valid && !p_ready) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(p_data));
         end
         if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte got %0h expected none", out_data);
            end else chk("byte", 32'(out_data), 32'(exp_q.pop_front()));
         end
         p_valid = out_valid;
         p_ready = out_ready;
         p_data  = out_data;
      end else p_valid = 1'b0;
   end

   task automatic expect_bytes(input logic [31:0] v, input logic [31:0] a);
      string s;
      if (v == 32'd11) exp_q.push_back(a[7:0]);
      else if (v == 32'd1) begin
         s = $sformatf("%0d", $signed(a));
         for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      end
   endtask

   function automatic int model_busy(input logic [31:0] v, input logic [31:0] a);
      longint m;
      string  s;
      int     n;
      if (v == 32'd11) return 2;
      if (v != 32'd1) return 1;
      m = longint'($signed(a));
      if (m < 0) m = -m;
      s = $sformatf("%0d", m);
      n = 1 + (a[31] ? 2 : 0) + (10 - s.len());
      for (int i = 0; i < s.len(); i++) n += int'(s[i]) - 48 + 2;
      return n;
   endfunction

   task automatic run_sys(input logic [31:0] v, input logic [31:0] a, input bit toggle, input string name);
      int n = 0;
      bit done = 0;
      @(posedge clk); #1;
      got_q.delete();
      expect_bytes(v, a);
      v0 = v;
      a0 = a;
      syscall_valid = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (busy) n++;
         else done = 1;
         if (!done) begin
            @(posedge clk); #1;
            if (toggle) out_ready = ~out_ready;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s timeout busy never dropped", name);
      end
      @(posedge clk); #1;
      syscall_valid = 1'b0;
      out_ready = 1'b1;
      if (!toggle) chk({name, "_busy_cycles"}, 32'(n), 32'(model_busy(v, a)));
      chk({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      chk({name, "_idle_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      bit seen = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_busy_low", 32'(busy), 32'd0);
      syscall_valid = 1'b1;
      #1 chk("rst_busy_follow", 32'(busy), 32'd1);
      syscall_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_sys(32'd11, 32'h41, 0, "char");
      chk("char_count", 32'(got_q.size()), 32'd1);
      chk("char_byte", 32'(got_q[0]), 32'h41);

      run_sys(32'd1, 32'd0, 0, "zero");
      chk("zero_count", 32'(got_q.size()), 32'd1);
      chk("zero_byte", 32'(got_q[0]), 32'h30);

      run_sys(32'd1, 32'h80000000, 0, "intmin");
      chk("intmin_count", 32'(got_q.size()), 32'd11);
      chk("intmin_sign", 32'(got_q[0]), 32'h2D);
      chk("intmin_last", 32'(got_q[10]), 32'h38);

      run_sys(32'd1, 32'd1005, 1, "toggle");
      chk("toggle_count", 32'(got_q.size()), 32'd4);
      chk("toggle_zero", 32'(got_q[1]), 32'h30);

      run_sys(32'd1, 32'hFFFFFF85, 0, "neg123");
      run_sys(32'd1, 32'd2147483647, 0, "intmax");
      run_sys(32'd4, 32'd99, 0, "unknown");
      chk("unknown_count", 32'(got_q.size()), 32'd0);

      // Print-int 7 held in EMIT by backpressure, then reset mid-byte.
      @(posedge clk); #1;
      v0 = 32'd1;
      a0 = 32'd7;
      syscall_valid = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      chk("abort_reached_emit", 32'(seen), 32'd1);
      chk("abort_byte", 32'(out_data), 32'h37);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_valid_drop", 32'(out_valid), 32'd0);
      chk("abort_data_clear", 32'(out_data), 32'd0);
      syscall_valid = 1'b0;
      exp_q.delete();
      got_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (30) @(posedge clk);
      #1 chk("abort_no_replay", 32'(got_q.size()), 32'd0);

      @(posedge clk); #1;
      v0 = 32'd10;
      syscall_valid = 1'b1;
      @(posedge clk); #1;
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_busy", 32'(busy), 32'd1);
      syscall_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 chk("halt_busy_hold", 32'(busy), 32'd1);
      v0 = 32'd11;
      a0 = 32'h42;
      syscall_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("halt_ignore_valid", 32'(out_valid), 32'd0);
      chk("halt_stays", 32'(halted), 32'd1);
      chk("halt_no_bytes", 32'(got_q.size()), 32'd0);
      syscall_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("halt_rst_halted", 32'(halted), 32'd0);
      chk("halt_rst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
